// File: rtl/simple_dual_port_memory_wrapper.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Write-first on same-address collision via an explicit bypass mux.
module simple_dual_port_memory_wrapper #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    addr_d,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic [AW-1:0]    addr_q,
  output logic [WIDTH-1:0] q
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok, rd_ok, byp;

  // Range checks only matter when DEPTH is not a power of two.
  assign wr_ok = ({1'b0, addr_d} < DEPTH_W);
  assign rd_ok = ({1'b0, addr_q} < DEPTH_W);
  assign byp   = en && wr_ok && (addr_d == addr_q);

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && en && wr_ok) mem[addr_d] <= d;
  end

  always_ff @(posedge clk) begin
    if (rst)         q <= '0;
    else if (!rd_ok) q <= '0;
    else if (byp)    q <= d;
    else             q <= mem[addr_q];
  end

endmodule

// File: tb/tb_simple_dual_port_memory_wrapper.sv
// Bench for simple_dual_port_memory_wrapper: 256x8 and 100x16 instances
// checked against an array-based reference model with directed and random stimulus.
module tb_simple_dual_port_memory_wrapper;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, DEPTH=256
  logic        rst0 = 1'b0, en0 = 1'b0;
  logic [7:0]  ad0 = '0, aq0 = '0, d0 = '0, q0;
  // Instance B: WIDTH=16, DEPTH=100
  logic        rst1 = 1'b0, en1 = 1'b0;
  logic [6:0]  ad1 = '0, aq1 = '0;
  logic [15:0] d1 = '0, q1;

  simple_dual_port_memory_wrapper #(.WIDTH(8), .DEPTH(256)) dut0 (
    .clk(clk), .rst(rst0), .addr_d(ad0), .d(d0), .en(en0), .addr_q(aq0), .q(q0));
  simple_dual_port_memory_wrapper #(.WIDTH(16), .DEPTH(100)) dut1 (
    .clk(clk), .rst(rst1), .addr_d(ad1), .d(d1), .en(en1), .addr_q(aq1), .q(q1));

  int npass = 0, ntot = 0;

  // Reference model: contents plus a "known" flag (power-up contents are undefined).
  logic [15:0] m0 [256];
  bit          k0 [256];
  logic [15:0] m1 [128];
  bit          k1 [128];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // One clock edge on instance A; the model predicts q from the spec's rules.
  task automatic step0(input string tag, input bit r, input bit e, input int ad,
                       input int aq, input int dd);
    logic [15:0] eq;
    bit          ek;
    rst0 = r; en0 = e; ad0 = 8'(ad); aq0 = 8'(aq); d0 = 8'(dd);
    @(posedge clk);
    if (r)                     begin eq = 0; ek = 1; end
    else if (e && ad == aq)    begin eq = 16'(dd & 8'hff); ek = 1; end
    else                       begin eq = m0[aq]; ek = k0[aq]; end
    if (!r && e) begin m0[ad] = 16'(dd & 8'hff); k0[ad] = 1; end
    #1;
    if (ek) chk(tag, {8'h0, q0}, eq);
  endtask

  task automatic step1(input string tag, input bit r, input bit e, input int ad,
                       input int aq, input int dd);
    logic [15:0] eq;
    bit          ek;
    rst1 = r; en1 = e; ad1 = 7'(ad); aq1 = 7'(aq); d1 = 16'(dd);
    @(posedge clk);
    if (r)                                begin eq = 0; ek = 1; end
    else if (aq >= 100)                   begin eq = 0; ek = 1; end
    else if (e && ad == aq)               begin eq = 16'(dd); ek = 1; end
    else                                  begin eq = m1[aq]; ek = k1[aq]; end
    if (!r && e && ad < 100) begin m1[ad] = 16'(dd); k1[ad] = 1; end
    #1;
    if (ek) chk(tag, q1, eq);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) k0[i] = 0;
    for (int i = 0; i < 128; i++) k1[i] = 0;
    rst1 = 1'b1;
    @(posedge clk); #1;

    // 1: reset suppresses writes and clears q; contents survive
    step0("rst_init", 1, 0, 0, 0, 0);
    step0("pre_wr3", 0, 1, 3, 0, 7);
    step0("rst_wr_a", 1, 1, 3, 3, 99);
    step0("rst_wr_b", 1, 1, 3, 3, 99);
    step0("rst_keep3", 0, 0, 0, 3, 0);
    chk("rst_keep3_abs", {8'h0, q0}, 16'd7);

    // 2: write then read, not visible before the read edge
    step0("wr3", 0, 1, 3, 4, 42);
    step0("rd3", 0, 0, 0, 3, 0);
    chk("rd3_abs", {8'h0, q0}, 16'd42);

    // 3: collision is write-first
    step0("coll5", 0, 1, 5, 5, 41);
    chk("coll5_abs", {8'h0, q0}, 16'd41);

    // 4: concurrent write/read at different addresses
    step0("conc", 0, 1, 10, 3, 8'hAA);
    chk("conc_abs", {8'h0, q0}, 16'd42);
    step0("rd10", 0, 0, 0, 10, 0);
    chk("rd10_abs", {8'h0, q0}, 16'hAA);

    // 6: reset pulse mid-stream
    step0("rst_mid", 1, 0, 0, 10, 0);
    chk("rst_mid_abs", {8'h0, q0}, 16'h0);
    step0("rd10_post", 0, 0, 0, 10, 0);
    chk("rd10_post_abs", {8'h0, q0}, 16'hAA);

    // 5: fill and sequential readback
    for (int a = 0; a < 256; a++) step0("fill0", 0, 1, a, 0, a);
    for (int a = 0; a < 256; a++) step0("scan0", 0, 0, 0, a, 0);

    // Random traffic on A
    for (int i = 0; i < 400; i++)
      step0("rand0", ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
            $urandom_range(0, 255), ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 255),
            $urandom_range(0, 255));

    // Instance B: non-power-of-two depth
    step1("rst1", 1, 0, 0, 0, 0);
    for (int a = 0; a < 100; a++) step1("fill1", 0, 1, a, 0, a);
    step1("oor_rd", 0, 0, 0, 100, 0);
    chk("oor_rd_abs", q1, 16'h0);
    step1("oor_wr", 0, 1, 120, 120, 16'hBEEF);
    chk("oor_wr_abs", q1, 16'h0);
    for (int a = 0; a < 100; a++) step1("scan1", 0, 0, 0, a, 0);
    step1("scan1_last", 0, 0, 0, 99, 0);
    chk("scan1_last_abs", q1, 16'd99);

    for (int i = 0; i < 400; i++)
      step1("rand1", ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
            $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 65535));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
